// File: rtl/johnson_counter_param.sv
// -----------------------------------------------------------------------------
// johnson_counter_param
//
// Parametrised Johnson (twisted-ring) counter with WIDTH ring bits and
// N = 2*WIDTH states. Intended as a glitch-free phase/sequence generator.
//
// The ring steps forward or in reverse while EN is high. The block also
// provides:
//   - a synchronous parallel load by state index;
//   - a registered binary state index and a one-hot decode of that index;
//   - a terminal-count flag;
//   - recovery from illegal ring patterns.
//
// State k encoding:
//   k in 0..WIDTH       : k ones, MSB-justified
//   k in WIDTH+1..N-1   : (N-k) ones, LSB-justified
//   e.g. WIDTH=4        : 0000,1000,1100,1110,1111,0111,0011,0001
//
// Handshake: none. Every input is sampled on each rising CLK edge. Each
// registered output (COUNT/IDX/ERR) updates one edge after its cause. DEC and
// TC are combinational views of the registers (TC also of current inputs).
//
// Ports:
//   CLK       in   1      rising-edge clock
//   CLR       in   1      synchronous reset, active-high (highest priority)
//   EN        in   1      count enable, one step per edge
//   DIR       in   1      1 = forward (S0->S1->...), 0 = reverse
//   LOAD      in   1      load state LOAD_IDX (EN/DIR ignored)
//   LOAD_IDX  in   IW     target state index 0..N-1
//   COUNT     out  WIDTH  registered ring value
//   IDX       out  IW     registered binary index of COUNT
//   DEC       out  N      one-hot decode of IDX
//   TC        out  1      terminal count: the next enabled step wraps
//   ERR       out  1      one-cycle pulse: rejected load or corrected ring
// -----------------------------------------------------------------------------
module johnson_counter_param #(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1,
    localparam int N           = 2 * WIDTH,
    localparam int IW          = $clog2(2 * WIDTH)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             DIR,
    input  logic             LOAD,
    input  logic [IW-1:0]    LOAD_IDX,
    output logic [WIDTH-1:0] COUNT,
    output logic [IW-1:0]    IDX,
    output logic [N-1:0]     DEC,
    output logic             TC,
    output logic             ERR
);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    // One bit wider than LOAD_IDX, so that N itself is representable
    // when N is a power of two.
    localparam logic [IW:0]   N_EXT    = (IW + 1)'(N);

    logic [WIDTH-1:0] count_q, count_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] fwd_ring;
    logic [WIDTH-1:0] rev_ring;
    logic [WIDTH-1:0] load_ring;
    logic             load_ok;
    logic             illegal;

    // Ring pattern for state index k, built from the encoding rule
    // rather than from a stored table.
    function automatic logic [WIDTH-1:0] ring_of_idx(input logic [IW-1:0] k);
        logic [WIDTH-1:0] r;
        int               ki;
        ki = int'(k);
        r  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ki <= WIDTH) r[i] = (i >= WIDTH - ki);
            else             r[i] = (i < N - ki);
        end
        return r;
    endfunction

    assign fwd_ring  = {~count_q[0], count_q[WIDTH-1:1]};
    assign rev_ring  = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
    assign load_ring = ring_of_idx(LOAD_IDX);
    assign load_ok   = ({1'b0, LOAD_IDX} < N_EXT);

    // A legal Johnson pattern is a single run of ones and a single run of
    // zeros. Read across the bit vector, it has at most one 0/1 boundary.
    // Two or more boundaries can only come from an upset.
    always_comb begin
        int trans;
        trans = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (count_q[i] != count_q[i+1]) trans++;
        end
        illegal = (trans > 1);
    end

    // Next state. The order is LOAD > illegal correction > EN step > hold.
    // CLR is applied in the register process.
    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        if (LOAD) begin
            if (load_ok) begin
                count_d = load_ring;
                idx_d   = LOAD_IDX;
            end else begin
                err_d   = 1'b1;
            end
        end else if (illegal && SELF_CORRECT) begin
            count_d = '0;
            idx_d   = '0;
            err_d   = 1'b1;
        end else if (EN) begin
            count_d = DIR ? fwd_ring : rev_ring;
            // Without correction an illegal ring still shifts. Its index
            // has no meaning, so IDX is frozen until the next load or clear.
            if (!illegal) begin
                if (DIR) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
                else     idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            count_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign COUNT = count_q;
    assign IDX   = idx_q;
    assign ERR   = err_q;
    assign DEC   = N'(1) << idx_q;
    assign TC    = EN & ~LOAD & ((DIR & (idx_q == IDX_LAST)) | (~DIR & (idx_q == '0)));

endmodule

// File: tb/tb_johnson_counter_param.sv
module tb_johnson_counter_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT instances ----------------
  // u4: WIDTH=4 (N=8, IW=3), self-correcting
  logic       clr4, en4, dir4, load4;
  logic [2:0] load_idx4;
  logic [3:0] count4;
  logic [2:0] idx4;
  logic [7:0] dec4;
  logic       tc4, err4;

  johnson_counter_param #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut4 (
    .CLK(clk), .CLR(clr4), .EN(en4), .DIR(dir4), .LOAD(load4), .LOAD_IDX(load_idx4),
    .COUNT(count4), .IDX(idx4), .DEC(dec4), .TC(tc4), .ERR(err4)
  );

  // u3: WIDTH=3 (N=6, IW=3)
  logic       clr3, en3, dir3, load3;
  logic [2:0] load_idx3;
  logic [2:0] count3;
  logic [2:0] idx3;
  logic [5:0] dec3;
  logic       tc3, err3;

  johnson_counter_param #(.WIDTH(3), .SELF_CORRECT(1'b1)) dut3 (
    .CLK(clk), .CLR(clr3), .EN(en3), .DIR(dir3), .LOAD(load3), .LOAD_IDX(load_idx3),
    .COUNT(count3), .IDX(idx3), .DEC(dec3), .TC(tc3), .ERR(err3)
  );

  // u5: WIDTH=5 (N=10, IW=4)
  logic       clr5, en5, dir5, load5;
  logic [3:0] load_idx5;
  logic [4:0] count5;
  logic [3:0] idx5;
  logic [9:0] dec5;
  logic       tc5, err5;

  johnson_counter_param #(.WIDTH(5), .SELF_CORRECT(1'b1)) dut5 (
    .CLK(clk), .CLR(clr5), .EN(en5), .DIR(dir5), .LOAD(load5), .LOAD_IDX(load_idx5),
    .COUNT(count5), .IDX(idx5), .DEC(dec5), .TC(tc5), .ERR(err5)
  );

  // ---------------- reference model ----------------
  // Ring value of state k: k ones MSB-justified, or (N-k) ones LSB-justified.
  function automatic int ring_of(input int k, input int w);
    int n;
    n = 2 * w;
    if (k <= w) return ((1 << k) - 1) << (w - k);
    else        return (1 << (n - k)) - 1;
  endfunction

  // Returns next index in bits [7:0] and the ERR value in bit 8.
  function automatic int next_state(input int idx, input int n, input bit clr,
                                    input bit load, input int lidx, input bit ill,
                                    input bit en, input bit dir);
    if (clr)  return 0;
    if (load) return (lidx < n) ? lidx : (idx | 256);
    if (ill)  return 256;
    if (en)   return dir ? (idx + 1) % n : (idx + n - 1) % n;
    return idx;
  endfunction

  function automatic bit exp_tc(input int idx, input int n, input bit en,
                                input bit load, input bit dir);
    return en && !load && ((dir && idx == n - 1) || (!dir && idx == 0));
  endfunction

  int m4_idx = 0, m3_idx = 0, m5_idx = 0;
  bit m4_err = 0, m3_err = 0, m5_err = 0;
  bit m4_v = 0, m3_v = 0, m5_v = 0;
  bit ill4 = 0, skip4 = 0;

  always @(posedge clk) begin
    int r;
    r = next_state(m4_idx, 8, clr4, load4, int'(load_idx4), ill4, en4, dir4);
    m4_idx = r & 255; m4_err = r[8]; if (clr4) m4_v = 1;
    r = next_state(m3_idx, 6, clr3, load3, int'(load_idx3), 1'b0, en3, dir3);
    m3_idx = r & 255; m3_err = r[8]; if (clr3) m3_v = 1;
    r = next_state(m5_idx, 10, clr5, load5, int'(load_idx5), 1'b0, en5, dir5);
    m5_idx = r & 255; m5_err = r[8]; if (clr5) m5_v = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m4_v && !skip4) begin
      check("u4_count", int'(count4), ring_of(m4_idx, 4));
      check("u4_idx",   int'(idx4),   m4_idx);
      check("u4_err",   int'(err4),   int'(m4_err));
      check("u4_dec",   int'(dec4),   1 << m4_idx);
      check("u4_tc",    int'(tc4),    int'(exp_tc(m4_idx, 8, en4, load4, dir4)));
    end
    if (m3_v) begin
      check("u3_count", int'(count3), ring_of(m3_idx, 3));
      check("u3_idx",   int'(idx3),   m3_idx);
      check("u3_err",   int'(err3),   int'(m3_err));
      check("u3_dec",   int'(dec3),   1 << m3_idx);
      check("u3_tc",    int'(tc3),    int'(exp_tc(m3_idx, 6, en3, load3, dir3)));
    end
    if (m5_v) begin
      check("u5_count", int'(count5), ring_of(m5_idx, 5));
      check("u5_idx",   int'(idx5),   m5_idx);
      check("u5_err",   int'(err5),   int'(m5_err));
      check("u5_dec",   int'(dec5),   1 << m5_idx);
      check("u5_tc",    int'(tc5),    int'(exp_tc(m5_idx, 10, en5, load5, dir5)));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp1[9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                  4'b0111, 4'b0011, 4'b0001, 4'b0000};
  int exp2[5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};

  initial begin
    clr4 = 1; en4 = 0; dir4 = 1; load4 = 0; load_idx4 = '0;
    clr3 = 1; en3 = 0; dir3 = 1; load3 = 0; load_idx3 = '0;
    clr5 = 1; en5 = 0; dir5 = 1; load5 = 0; load_idx5 = '0;
    tick();
    clr4 = 0; clr3 = 0; clr5 = 0;
    check("reset_count", int'(count4), 0);
    check("reset_idx",   int'(idx4),   0);
    check("reset_dec",   int'(dec4),   1);
    check("reset_err",   int'(err4),   0);

    // Test 1: forward through a full wrap
    en4 = 1; dir4 = 1; #1;
    for (int i = 0; i < 9; i++) begin
      check("t1_count", int'(count4), exp1[i]);
      check("t1_tc",    int'(tc4),    (i == 7) ? 1 : 0);
      if (i < 8) tick();
    end

    // Test 2: reverse from IDX=0
    dir4 = 0; #1;
    check("t2_tc_at0", int'(tc4), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_count", int'(count4), exp2[i]);
      check("t2_idx",   int'(idx4),   7 - i);
      check("t2_tc",    int'(tc4),    0);
    end

    // Test 3: load with EN high, then CLR beats LOAD
    load4 = 1; load_idx4 = 3'd5;
    tick();
    check("t3_count", int'(count4), 4'b0111);
    check("t3_idx",   int'(idx4),   5);
    check("t3_dec",   int'(dec4),   8'b0010_0000);
    clr4 = 1;
    tick();
    check("t3_clr_count", int'(count4), 0);
    check("t3_clr_idx",   int'(idx4),   0);
    clr4 = 0; load4 = 0; en4 = 0;

    // Test 5: illegal pattern correction with EN low
    tick();
    skip4 = 1; ill4 = 1;
    force dut4.count_q = 4'b1010;
    #1;
    release dut4.count_q;
    tick();
    ill4 = 0; skip4 = 0;
    check("t5_count", int'(count4), 0);
    check("t5_idx",   int'(idx4),   0);
    check("t5_err",   int'(err4),   1);
    en4 = 1; dir4 = 1;
    tick();
    check("t5_resume_count", int'(count4), 4'b1000);
    check("t5_resume_err",   int'(err4),   0);
    en4 = 0;

    // Test 4: WIDTH=3, out-of-range loads are rejected
    load3 = 1; load_idx3 = 3'd2;
    tick();
    check("t4_base", int'(count3), 3'b110);
    load_idx3 = 3'd6;
    tick();
    check("t4_rej6_count", int'(count3), 3'b110);
    check("t4_rej6_err",   int'(err3),   1);
    load3 = 0;
    tick();
    check("t4_err_drop6", int'(err3), 0);
    load3 = 1; load_idx3 = 3'd7;
    tick();
    check("t4_rej7_idx", int'(idx3), 2);
    check("t4_rej7_err", int'(err3), 1);
    load3 = 0;
    tick();
    check("t4_err_drop7", int'(err3), 0);
    load3 = 1; load_idx3 = 3'd5;
    tick();
    check("t4_load5", int'(count3), 3'b001);
    load3 = 0;
    tick();

    // Test 6: WIDTH=5 random EN/DIR/LOAD, checked every cycle by the model
    for (int i = 0; i < 2000; i++) begin
      en5       = 1'($urandom_range(0, 1));
      dir5      = 1'($urandom_range(0, 1));
      load5     = ($urandom_range(0, 15) == 0);
      load_idx5 = 4'($urandom_range(0, 9));
      tick();
    end
    en5 = 0; load5 = 0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
